// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, pausable down-counter used as a countdown timer.
// A loaded start value counts down while enabled in RUN; a one-cycle done
// pulse marks the edge where the count reaches zero.
// Optional feature macro: DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
//   undefined -> one-shot: return to IDLE on reaching zero.
//   defined   -> periodic: stay in RUN and reload the last loaded value on the
//                enabled edge after zero (period reload + 1 enabled cycles).
module down_counter_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             stop,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t state_r;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_r;
`endif

   // Control FSM and counter: priority load > stop > start > en.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         q        <= CNT_ZERO;
         done     <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
         reload_r <= CNT_ZERO;
`endif
      end else begin
         done <= 1'b0;
         if (load) begin
            q       <= load_val;
            state_r <= IDLE;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload_r <= load_val;
`endif
         end else begin
            case (state_r)
               IDLE: begin
                  // A zero count has nothing to time, so start is ignored.
                  if (start && (q != CNT_ZERO)) begin
                     state_r <= RUN;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               RUN: begin
                  if (stop) begin
                     state_r <= IDLE;
                  end else if (en) begin
                     if (q == CNT_ONE) begin
                        q    <= CNT_ZERO;
                        done <= 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        state_r <= RUN;
`else
                        state_r <= IDLE;
`endif
                     end else if (q == CNT_ZERO) begin
                        // Only reachable in periodic mode, after a done edge.
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        if (reload_r == CNT_ZERO) begin
                           state_r <= IDLE;
                        end else begin
                           q       <= reload_r;
                           state_r <= RUN;
                        end
`else
                        state_r <= IDLE;
`endif
                     end else begin
                        q <= q - CNT_ONE;
                     end
                  end else begin
                     state_r <= RUN;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy = (state_r == RUN);
   assign zero = (q == CNT_ZERO);

endmodule

// File: tb/tb_down_counter_timer.sv
// Testbench for down_counter_timer (WIDTH = 4): directed vector table plus
// randomized stimulus checked against a behavioural reference model.
module tb_down_counter_timer;

   logic       clk;
   logic       rst;
   logic       load;
   logic [3:0] load_val;
   logic       start;
   logic       stop;
   logic       en;
   logic [3:0] q;
   logic       busy;
   logic       done;
   logic       zero;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int  m_q;
   int  m_reload;
   bit  m_run;
   bit  m_done;

   typedef struct {
      logic       ld;
      logic [3:0] lv;
      logic       st;
      logic       sp;
      logic       en;
      logic [3:0] eq;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t vecs[$];

   down_counter_timer #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .start    (start),
      .stop     (stop),
      .en       (en),
      .q        (q),
      .busy     (busy),
      .done     (done),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q = 0; m_reload = 0; m_run = 1'b0; m_done = 1'b0;
   endtask

   // Behavioural rule set, one call per rising edge.
   task automatic model_edge(input bit ld, input int lv, input bit st, input bit sp, input bit e);
      m_done = 1'b0;
      if (ld) begin
         m_q = lv; m_reload = lv; m_run = 1'b0;
      end else if (m_run && sp) begin
         m_run = 1'b0;
      end else if (!m_run) begin
         if (st && m_q != 0) m_run = 1'b1;
      end else if (e) begin
         if (m_q == 0) begin
            if (m_reload == 0) m_run = 1'b0;
            else m_q = m_reload;
         end else begin
            m_q = m_q - 1;
            if (m_q == 0) begin
               m_done = 1'b1;
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
               m_run = 1'b0;
`endif
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_q"},    32'(q),    32'(m_q));
      chk({tag, "_busy"}, 32'(busy), 32'(m_run));
      chk({tag, "_done"}, 32'(done), 32'(m_done));
      chk({tag, "_zero"}, 32'(zero), 32'(m_q == 0));
   endtask

   // Entered and left at posedge+1.
   task automatic step(input bit ld, input logic [3:0] lv, input bit st, input bit sp, input bit e,
                       input string tag);
      load = ld; load_val = lv; start = st; stop = sp; en = e;
      @(posedge clk);
      model_edge(ld, int'(lv), st, sp, e);
      #1;
      check_model(tag);
   endtask

   // Asynchronous reset between edges, checked before any clock edge.
   task automatic async_reset();
      load = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
      #3;
      rst = 1'b1;
      model_reset();
      #1;
      check_model("rst_assert");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_model("rst_release");
   endtask

   function automatic void add(input logic ld, input logic [3:0] lv, input logic st, input logic sp,
                               input logic e, input logic [3:0] eq, input logic eb, input logic ed);
      vec_t v;
      v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.en = e;
      v.eq = eq; v.eb = eb; v.ed = ed;
      vecs.push_back(v);
   endfunction

   initial begin
      rst = 1'b1; load = 1'b0; load_val = 4'd0; start = 1'b0; stop = 1'b0; en = 1'b0;
      model_reset();

`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
      // One-shot count from 5
      add(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0);
      // Pause and stop from 9
      add(1'b1, 4'd9,  1'b0, 1'b0, 1'b0, 4'd9,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd9,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd8,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd6,  1'b1, 1'b0);
      for (int i = 0; i < 4; i++) add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd6,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd6,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd3,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 1'b1);
      // Priority and corner cases
      add(1'b1, 4'd3,  1'b1, 1'b0, 1'b1, 4'd3,  1'b0, 1'b0);
      add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0);
      add(1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 4'd8,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd8,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd7,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd6,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd4,  1'b1, 1'b0);
      add(1'b1, 4'd15, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 4'd15, 1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
`else
      // Periodic tick with reload value 2
      add(1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 4'd2,  1'b0, 1'b0);
      add(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd0,  1'b1, 1'b1);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd2,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 4'd1,  1'b1, 1'b0);
      add(1'b0, 4'd0,  1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 1'b0);
`endif

      // Reset state, checked before the first clock edge
      #3;
      check_model("reset");
      chk("reset_q_const", 32'(q), 32'd0);
      chk("reset_zero_const", 32'(zero), 32'd1);
      #4;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_model("reset_hold");

      // Directed vector table
      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].sp, vecs[i].en, $sformatf("vec%0d", i));
         chk($sformatf("tbl%0d_q", i),    32'(q),    32'(vecs[i].eq));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].eb));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vecs[i].ed));
         chk($sformatf("tbl%0d_zero", i), 32'(zero), 32'(vecs[i].eq == 4'd0));
      end

      // Reset mid-run: load 10, run to 7, then async reset
      step(1'b1, 4'd10, 1'b0, 1'b0, 1'b0, "mid_load");
      step(1'b0, 4'd0,  1'b1, 1'b0, 1'b1, "mid_start");
      for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "mid_run");
      chk("mid_q7", 32'(q), 32'd7);
      async_reset();
      chk("mid_rst_q", 32'(q), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, "post_rst");

      // Randomized stimulus against the reference model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
         end else begin
            step($urandom_range(0, 9) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0,
                 "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
